// File: rtl/tdm_slot_demux.sv
// tdm_slot_demux
//   Receive side of a two-slot time-multiplexed link. This block owns the
//   free-running slot timer, drives it to the transmitter, and splits the
//   returned interleaved word stream into two first-word-fall-through FIFOs.
//
//   Slot attribution: the transmitter samples timer value t and returns the
//   word one edge later, so the incoming word belongs to channel ~timer[0]
//   (timer odd -> ch0, timer even -> ch1).
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   timer                  16-bit free-running slot timer (to transmitter)
//   in_data, in_valid      interleaved word stream from the transmitter
//   chX_data, chX_valid    FIFO head and non-empty flag for channel X
//   chX_ready              consumer accepts chX_data this cycle
//   chX_drops              saturating count of words lost to a full FIFO
module tdm_slot_demux #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [15:0]      timer,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] ch0_data,
  output logic             ch0_valid,
  input  logic             ch0_ready,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch1_valid,
  input  logic             ch1_ready,
  output logic [CNT_W-1:0] ch0_drops,
  output logic [CNT_W-1:0] ch1_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [15:0] timer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= 16'd0;
    else        timer_q <= timer_q + 16'd1;
  end

  assign timer = timer_q;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    // ch0 owns the odd timer values, ch1 the even ones
    localparam bit ODD_SLOT = (c == 0);

    logic             push;
    logic             ready;
    logic             pop;
    logic             accept;
    logic             empty;
    logic             full;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head;
    logic [CNT_W-1:0] drops;

    assign push  = in_valid && (timer_q[0] == ODD_SLOT);
    assign ready = (c == 0) ? ch0_ready : ch1_ready;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop = !empty && ready;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign accept = push && (!full || pop);
    assign head   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        drops  <= '0;
        // Storage is cleared so the head never reads back as X after reset.
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (accept) begin
          mem[wr_ptr[AW-1:0]] <= in_data;
          wr_ptr              <= wr_ptr + PTR_ONE;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !accept && (drops != '1)) drops <= drops + CNT_ONE;
      end
    end
  end

  assign ch0_data  = g_ch[0].head;
  assign ch0_valid = !g_ch[0].empty;
  assign ch0_drops = g_ch[0].drops;
  assign ch1_data  = g_ch[1].head;
  assign ch1_valid = !g_ch[1].empty;
  assign ch1_drops = g_ch[1].drops;

endmodule

// File: tb/tb_tdm_slot_demux.sv
module tb_tdm_slot_demux;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int DMAX  = 255;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      timer;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] ch0_data, ch1_data;
  logic             ch0_valid, ch1_valid;
  logic             ch0_ready, ch1_ready;
  logic [CNT_W-1:0] ch0_drops, ch1_drops;

  tdm_slot_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .timer(timer),
    .in_data(in_data), .in_valid(in_valid),
    .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .ch0_drops(ch0_drops), .ch1_drops(ch1_drops)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: two queues, two drop counts, a timer value.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          md0, md1;
  logic [15:0] mtimer;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r0, r1;
    logic [15:0] t;
    logic        v0;
    logic [15:0] d0;
    logic        v1;
    logic [15:0] d1;
  } vec_t;

  vec_t tab[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    md0 = 0;
    md1 = 0;
    mtimer = 16'd0;
  endtask

  // One edge of the specified behaviour, using the inputs held across it.
  task automatic model_edge();
    bit          p0, p1, f0, f1, push0, push1;
    logic [15:0] tmp;
    p0    = (q0.size() != 0) && ch0_ready;
    p1    = (q1.size() != 0) && ch1_ready;
    f0    = (q0.size() == DEPTH);
    f1    = (q1.size() == DEPTH);
    push0 = in_valid && (mtimer % 2 == 1);
    push1 = in_valid && (mtimer % 2 == 0);
    if (p0) tmp = q0.pop_front();
    if (p1) tmp = q1.pop_front();
    if (push0) begin
      if (!f0 || p0) q0.push_back(in_data);
      else if (md0 < DMAX) md0++;
    end
    if (push1) begin
      if (!f1 || p1) q1.push_back(in_data);
      else if (md1 < DMAX) md1++;
    end
    mtimer = mtimer + 16'd1;
  endtask

  task automatic check_model();
    chk("timer", timer, mtimer);
    chk("ch0_valid", ch0_valid, q0.size() != 0);
    chk("ch1_valid", ch1_valid, q1.size() != 0);
    if (q0.size() != 0) chk("ch0_data", ch0_data, q0[0]);
    if (q1.size() != 0) chk("ch1_data", ch1_data, q1[0]);
    chk("ch0_drops", ch0_drops, md0);
    chk("ch1_drops", ch1_drops, md1);
  endtask

  // Called at a negedge; drives inputs, crosses one posedge, checks at next negedge.
  task automatic step(input logic v, input logic [15:0] d, input logic r0, input logic r1);
    in_valid  = v;
    in_data   = d;
    ch0_ready = r0;
    ch1_ready = r1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; ch0_ready = 1'b0; ch1_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_timer", timer, 16'd0);
    chk("rst_v0", ch0_valid, 1'b0);
    chk("rst_v1", ch1_valid, 1'b0);
    chk("rst_d0", ch0_data, 16'd0);
    chk("rst_d1", ch1_data, 16'd0);
    chk("rst_drops0", ch0_drops, 0);
    chk("rst_drops1", ch1_drops, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    // Interleaved stream, in_data = timer, both consumers always ready.
    tab[0] = '{1'b1, 16'd0, 1'b1, 1'b1, 16'd1, 1'b0, 16'd0, 1'b1, 16'd0};
    tab[1] = '{1'b1, 16'd1, 1'b1, 1'b1, 16'd2, 1'b1, 16'd1, 1'b0, 16'd0};
    tab[2] = '{1'b1, 16'd2, 1'b1, 1'b1, 16'd3, 1'b0, 16'd0, 1'b1, 16'd2};
    tab[3] = '{1'b1, 16'd3, 1'b1, 1'b1, 16'd4, 1'b1, 16'd3, 1'b0, 16'd0};
    tab[4] = '{1'b1, 16'd4, 1'b1, 1'b1, 16'd5, 1'b0, 16'd0, 1'b1, 16'd4};
    tab[5] = '{1'b1, 16'd5, 1'b1, 1'b1, 16'd6, 1'b1, 16'd5, 1'b0, 16'd0};
    tab[6] = '{1'b1, 16'd6, 1'b1, 1'b1, 16'd7, 1'b0, 16'd0, 1'b1, 16'd6};
    tab[7] = '{1'b1, 16'd7, 1'b1, 1'b1, 16'd8, 1'b1, 16'd7, 1'b0, 16'd0};
    tab[8] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd9, 1'b0, 16'd0, 1'b0, 16'd0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      step(tab[i].v, tab[i].d, tab[i].r0, tab[i].r1);
      chk("tab_timer", timer, tab[i].t);
      chk("tab_v0", ch0_valid, tab[i].v0);
      chk("tab_v1", ch1_valid, tab[i].v1);
      if (tab[i].v0) chk("tab_d0", ch0_data, tab[i].d0);
      if (tab[i].v1) chk("tab_d1", ch1_data, tab[i].d1);
    end
    chk("tab_drops0", ch0_drops, 0);
    chk("tab_drops1", ch1_drops, 0);

    // ch0 overflow with consumer stalled: 6 words, 4 kept, 2 dropped.
    n = 0;
    while (n < 6) begin
      if (mtimer % 2 == 1) begin
        step(1'b1, 16'hA0 + 16'(n), 1'b0, 1'b1);
        n++;
      end else step(1'b0, 16'h0, 1'b0, 1'b1);
    end
    chk("ovf_drops0", ch0_drops, 2);
    chk("ovf_drops1", ch1_drops, 0);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_v0", ch0_valid, 1'b1);
      chk("ovf_pop_d0", ch0_data, 16'hA0 + 16'(i));
      step(1'b0, 16'h0, 1'b1, 1'b1);
    end
    chk("ovf_empty0", ch0_valid, 1'b0);

    // ch1 full, then push and pop on the same edge.
    n = 0;
    while (n < 4) begin
      if (mtimer % 2 == 0) begin
        step(1'b1, 16'hB0 + 16'(n), 1'b1, 1'b0);
        n++;
      end else step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    if (mtimer % 2 == 1) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("full_head1", ch1_data, 16'hB0);
    step(1'b1, 16'hB4, 1'b1, 1'b1);
    chk("full_drops1", ch1_drops, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("full_pop_v1", ch1_valid, 1'b1);
      chk("full_pop_d1", ch1_data, 16'hB0 + 16'(i));
      step(1'b0, 16'h0, 1'b1, 1'b1);
    end
    chk("full_empty1", ch1_valid, 1'b0);

    // Mid-stream reset with 3 words in each FIFO.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 16'h10 + 16'(i), 1'b0, 1'b0);
    chk("pre_rst_d0", ch0_data, 16'h11);
    chk("pre_rst_d1", ch1_data, 16'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_v0", ch0_valid, 1'b0);
    chk("mid_rst_v1", ch1_valid, 1'b0);
    chk("mid_rst_timer", timer, 16'd0);
    chk("mid_rst_drops0", ch0_drops, 0);
    chk("mid_rst_drops1", ch1_drops, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h55, 1'b0, 1'b0);
    chk("post_rst_v1", ch1_valid, 1'b1);
    chk("post_rst_d1", ch1_data, 16'h55);
    chk("post_rst_v0", ch0_valid, 1'b0);

    // Drop counter saturation on ch0.
    n = 0;
    while (n < 304) begin
      if (mtimer % 2 == 1) begin
        step(1'b1, 16'(n), 1'b0, 1'b1);
        n++;
      end else step(1'b0, 16'h0, 1'b0, 1'b1);
    end
    chk("sat_drops0", ch0_drops, DMAX);
    chk("sat_drops1", ch1_drops, 0);
    repeat (6) step(1'b0, 16'h0, 1'b1, 1'b1);

    // Random traffic until just before the timer wrap.
    while (mtimer < 16'hFFF0)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    while (mtimer != 16'hFFFF) step(1'b0, 16'h0, 1'b1, 1'b1);
    chk("wrap_pre_v0", ch0_valid, 1'b0);
    chk("wrap_pre_v1", ch1_valid, 1'b0);
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    chk("wrap_timer0", timer, 16'h0000);
    chk("wrap_v0", ch0_valid, 1'b1);
    chk("wrap_d0", ch0_data, 16'h1111);
    chk("wrap_v1a", ch1_valid, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    chk("wrap_timer1", timer, 16'h0001);
    chk("wrap_v1", ch1_valid, 1'b1);
    chk("wrap_d1", ch1_data, 16'h2222);
    chk("wrap_d0_hold", ch0_data, 16'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
